// File: rtl/rst_seq.sv
// Reset sequencer: merges board reset, a debounced pushbutton and a soft-reset
// pulse into one registered, minimum-width system reset, and counts accepted presses.
module rst_seq #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int HOLD_CYCLES     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    input  logic       ext_req,
    output logic       sys_rst,
    output logic [7:0] press_cnt
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_W = $clog2(HOLD_CYCLES);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        HOLD     = 2'd0,
        RUN      = 2'd1,
        WAIT_REL = 2'd2
    } state_t;

    logic              s1_reg;
    logic              s2_reg;
    logic              stable_reg;
    logic              stable_d_reg;
    logic [DB_W-1:0]   db_cnt_reg;
    logic [7:0]        press_cnt_reg;
    logic [HOLD_W-1:0] hold_cnt_reg;
    logic [HOLD_W-1:0] hold_cnt_next;
    state_t            state_reg;
    state_t            state_next;
    logic              sys_rst_reg;
    logic              press;

    // Two-flop synchronizer for the asynchronous button.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_reg <= 1'b0;
            s2_reg <= 1'b0;
        end else begin
            s1_reg <= btn;
            s2_reg <= s1_reg;
        end
    end

    // Any bounce back to the accepted level restarts the qualification count.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable_reg   <= 1'b0;
            stable_d_reg <= 1'b0;
            db_cnt_reg   <= '0;
        end else begin
            stable_d_reg <= stable_reg;
            if (s2_reg == stable_reg) begin
                db_cnt_reg <= '0;
            end else if (db_cnt_reg == DB_LAST) begin
                stable_reg <= s2_reg;
                db_cnt_reg <= '0;
            end else begin
                db_cnt_reg <= db_cnt_reg + 1'b1;
            end
        end
    end

    assign press = stable_reg & ~stable_d_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            press_cnt_reg <= 8'd0;
        end else if (press) begin
            press_cnt_reg <= press_cnt_reg + 8'd1;
        end
    end

    always_comb begin
        state_next    = state_reg;
        hold_cnt_next = hold_cnt_reg;
        case (state_reg)
            HOLD: begin
                if (press || ext_req) begin
                    hold_cnt_next = '0;
                end else if (hold_cnt_reg == HOLD_LAST) begin
                    hold_cnt_next = '0;
                    state_next    = stable_reg ? WAIT_REL : RUN;
                end else begin
                    hold_cnt_next = hold_cnt_reg + 1'b1;
                end
            end
            RUN: begin
                // A press outranks a simultaneous soft request.
                if (press) begin
                    state_next = WAIT_REL;
                end else if (ext_req) begin
                    state_next    = HOLD;
                    hold_cnt_next = '0;
                end
            end
            WAIT_REL: begin
                if (!stable_reg) begin
                    state_next    = HOLD;
                    hold_cnt_next = '0;
                end
            end
            default: begin
                state_next    = HOLD;
                hold_cnt_next = '0;
            end
        endcase
    end

    // sys_rst is registered from the next state so it is glitch-free and in step with the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= HOLD;
            hold_cnt_reg <= '0;
            sys_rst_reg  <= 1'b1;
        end else begin
            state_reg    <= state_next;
            hold_cnt_reg <= hold_cnt_next;
            sys_rst_reg  <= (state_next != RUN);
        end
    end

    assign sys_rst   = sys_rst_reg;
    assign press_cnt = press_cnt_reg;

endmodule
